muldiv_hilo: RTL and testbench
==============================

Name: muldiv_hilo

Overview:
Sequential multiply/divide unit and HI/LO register pair for the MIPS pipeline. It accepts operands from the EX stage and computes the product or quotient/remainder iteratively, one bit per cycle. Results land in HI/LO, and HI/LO are read back by mfhi/mflo. It is the HI/LO-side consumer of the dual-result EX datapath: it holds busy (pipeline stall) while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH
DIV0_LO, 32'hFFFF_FFFF, value written to LO on divide-by-zero

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
md_start  input  1  request; sampled only when state is IDLE
md_op  input  2  00 multu, 01 divu, 10 mthi, 11 mtlo
md_a  input  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo data)
md_b  input  WIDTH  rt operand (multiplier/divisor)
md_flush  input  1  pipeline flush; aborts an in-flight op
md_busy  output  1  high while iterating; drives the pipeline stall
md_done  output  1  one-cycle pulse when HI/LO are updated by mult/div
hi_out  output  WIDTH  current HI register
lo_out  output  WIDTH  current LO register

Behaviour:
- Reset: state=IDLE; hi_out=0, lo_out=0, md_busy=0, md_done=0, and all internal accumulators and counters cleared. Reset has priority over every other input, including mid-operation: the op is abandoned and HI/LO are zeroed.
- States: IDLE, MUL, DIV, DONE.
- IDLE, md_start=1, md_op=10/11: HI (resp. LO) is written with md_a at that edge. No busy, no md_done, state stays IDLE.
- IDLE, md_start=1, md_op=00/01: operands are latched, counter set to WIDTH, next state MUL or DIV. md_busy=1 from the next cycle.
- MUL: shift-add, one multiplier bit per cycle, on a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle, with partial remainder WIDTH+1 bits.
- Iteration: the counter decrements each cycle. After WIDTH iterations the next state is DONE.
- Entering DONE: HI/LO are written at that edge. MUL writes HI=product[63:32], LO=product[31:0]. DIV writes HI=remainder, LO=quotient. md_busy falls. md_done=1 for the single DONE cycle, then the state returns to IDLE.
- Latency: accept edge at T0; md_busy high for cycles T0+1..T0+WIDTH; md_done high in cycle T0+WIDTH+1 with the new HI/LO visible.
- DONE accepts md_start the same as IDLE, so back-to-back ops lose no cycle.
- md_start while MUL/DIV is ignored; no queueing.
- Divide by zero (md_b=0 at accept): normal latency; HI=md_a, LO=DIV0_LO.
- md_flush in MUL/DIV: return to IDLE next edge, HI/LO unchanged, no md_done.
- md_flush in IDLE/DONE: no effect. md_start and md_flush together in IDLE: flush wins, request dropped.
- hi_out/lo_out come straight from the registers, so a read in the write cycle returns the old value. The EX/WB bypass is the pipeline's job.

Optional Feature:
Macro MULDIV_SIGNED_EN.
- Defined: adds input md_signed (1 bit), sampled with md_start. When set:
  - Operands are converted to magnitudes before iterating; results are sign-corrected in DONE with no extra cycle.
  - Product sign = sign(a) XOR sign(b). Quotient truncates toward zero; remainder takes the dividend's sign.
  - Overflow case 32'h8000_0000 / -1 gives LO=32'h8000_0000, HI=0.
  - Divide-by-zero follows the rule above.
- Undefined: the port is absent and all ops are unsigned.

Decomposition:
- Shared package: md_op encodings (MD_MULTU, MD_DIVU, MD_MTHI, MD_MTLO), state enum, WIDTH default, DIV0_LO default.
- One natural sub-module, muldiv_iter: the datapath (accumulator, shift, add/subtract, counter). The top holds the FSM and the HI/LO registers.

Test Plan:
- multu a=32'hFFFF_FFFF, b=2 -> busy 32 cycles, md_done in cycle 33; HI=1, LO=32'hFFFF_FFFE.
- divu a=100, b=7 -> LO=14, HI=2; second divu issued in the DONE cycle (a=9, b=3) -> LO=3, HI=0, exactly 33 cycles later.
- divu a=55, b=0 -> HI=55, LO=32'hFFFF_FFFF after normal latency.
- mthi 32'hDEAD_BEEF then mtlo 32'h1234 on consecutive cycles -> hi_out/lo_out update next edge; md_busy stays 0.
- multu in flight, md_flush at cycle 10 -> busy drops next cycle, HI/LO keep their prior values, no md_done. Repeat with rst at cycle 10 -> HI=LO=0.
- With MULDIV_SIGNED_EN: signed divide -7/2 -> LO=-3, HI=-1; signed multiply -3*4 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF4.

Source files
------------

// File: rtl/muldiv_hilo_pkg.sv
//------------------------------------------------------------------------------
// muldiv_hilo_pkg : shared encodings and defaults for the HI/LO mul/div unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_hilo_pkg;

    localparam int          MD_WIDTH   = 32;
    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_DIVU  = 2'b01,
        MD_MTHI  = 2'b10,
        MD_MTLO  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
//------------------------------------------------------------------------------
// muldiv_iter : one-bit-per-cycle shift-add multiply / restoring divide datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_iter
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   acc_next_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mul_step, div_step;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;

    // The accumulator holds {upper, lower}: for multiply the lower half is the
    // remaining multiplier bits; for divide it is {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        div_step  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end

    assign acc_next_o = is_div_i ? div_step : mul_step;
    assign last_o     = (cnt_q == CW'(1));

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            acc_d  = {{WIDTH{1'b0}}, a_i};
            opnd_d = b_i;
            cnt_d  = CW'(WIDTH);
        end else if (step_i) begin
            acc_d  = acc_next_o;
            cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_hilo.sv
//------------------------------------------------------------------------------
// muldiv_hilo : iterative multiply/divide unit with HI/LO registers (FSM + HI/LO)
// Optional signed operation enabled by defining MULDIV_SIGNED_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int               WIDTH   = MD_WIDTH,
    parameter logic [WIDTH-1:0] DIV0_LO = WIDTH'(MD_DIV0_LO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             md_flush,
`ifdef MULDIV_SIGNED_EN
    input  logic             md_signed,
`endif
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div0_q, div0_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
    logic               sgn_req, accept, load, iter_last;
    logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] iter_next, prod_fix;

`ifdef MULDIV_SIGNED_EN
    assign sgn_req = md_signed;
`else
    assign sgn_req = 1'b0;
`endif

    assign accept = md_start && !md_flush;
    assign a_mag  = (sgn_req && md_a[WIDTH-1]) ? -md_a : md_a;
    assign b_mag  = (sgn_req && md_b[WIDTH-1]) ? -md_b : md_b;

    muldiv_iter #(
        .WIDTH      (WIDTH)
    ) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (md_busy),
        .is_div_i   (state_q == ST_DIV),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .last_o     (iter_last),
        .acc_next_o (iter_next)
    );

    // Sign correction is applied to the final step's value so DONE needs no extra cycle.
    assign prod_fix = neg_p_q ? -iter_next : iter_next;
    assign quot_fix = neg_p_q ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
    assign rem_fix  = neg_r_q ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = div0_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    case (md_op)
                        MD_MTHI: hi_d = md_a;
                        MD_MTLO: lo_d = md_a;
                        default: begin
                            load    = 1'b1;
                            state_d = (md_op == MD_DIVU) ? ST_DIV : ST_MUL;
                            div0_d  = (md_b == '0);
                            neg_p_d = sgn_req && (md_a[WIDTH-1] ^ md_b[WIDTH-1]);
                            neg_r_d = sgn_req && md_a[WIDTH-1];
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_flush) begin
                    state_d = ST_IDLE;
                end else if (iter_last) begin
                    state_d = ST_DONE;
                    if (state_q == ST_DIV) begin
                        hi_d = rem_fix;
                        lo_d = div0_q ? DIV0_LO : quot_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            div0_q  <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
        end
    end

    assign md_busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign md_done = (state_q == ST_DONE);
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
//------------------------------------------------------------------------------
// tb_muldiv_hilo : self-checking bench for muldiv_hilo (reference model + directed)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         md_start = 1'b0;
    logic         md_flush = 1'b0;
    logic [1:0]   md_op = 2'b00;
    logic [W-1:0] md_a = '0;
    logic [W-1:0] md_b = '0;
    logic         md_busy, md_done;
    logic [W-1:0] hi_out, lo_out;
    logic         sgn_now;
`ifdef MULDIV_SIGNED_EN
    logic         md_signed = 1'b0;
    assign sgn_now = md_signed;
`else
    assign sgn_now = 1'b0;
`endif

    muldiv_hilo dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_flush (md_flush),
`ifdef MULDIV_SIGNED_EN
        .md_signed(md_signed),
`endif
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference results straight from arithmetic: returns {HI, LO}.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic sgn);
        int     sa, sb;
        longint pa;
        sa = a;
        sb = b;
        if (op == 2'b00) begin
            if (sgn) begin
                pa = longint'(sa) * longint'(sb);
                return pa;
            end
            return {32'b0, a} * {32'b0, b};
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            if (md_flush) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (md_start && !md_flush) begin
                case (md_op)
                    2'b10:   m_hi = md_a;
                    2'b11:   m_lo = md_a;
                    default: begin
                        {p_hi, p_lo} = ref_result(md_op, md_a, md_b, sgn_now);
                        m_left = W;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 64'(md_busy), 64'(m_left > 0));
            chk("done", 64'(md_done), 64'(m_done));
            chk("hi", 64'(hi_out), 64'(m_hi));
            chk("lo", 64'(lo_out), 64'(m_lo));
            if (md_done) done_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge of the md_done cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        @(negedge clk);
        md_start = 1'b0;
        lat = 1;
        while (md_done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, d0, r;

    initial begin
        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi_out), 64'h0);
        chk("rst_lo", 64'(lo_out), 64'h0);
        chk("rst_busy", 64'(md_busy), 64'h0);
        chk("rst_done", 64'(md_done), 64'h0);
        rst = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, lat);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_hi", 64'(hi_out), 64'h1);
        chk("mul_lo", 64'(lo_out), 64'hFFFF_FFFE);

        run_op(2'b01, 32'd100, 32'd7, lat);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_hi", 64'(hi_out), 64'd2);
        chk("div_lo", 64'(lo_out), 64'd14);
        run_op(2'b01, 32'd9, 32'd3, lat);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_hi", 64'(hi_out), 64'd0);
        chk("b2b_lo", 64'(lo_out), 64'd3);

        run_op(2'b01, 32'd55, 32'd0, lat);
        chk("div0_lat", 64'(lat), 64'd33);
        chk("div0_hi", 64'(hi_out), 64'd55);
        chk("div0_lo", 64'(lo_out), 64'hFFFF_FFFF);

        @(negedge clk);
        md_start = 1'b1; md_op = 2'b10; md_a = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mthi_hi", 64'(hi_out), 64'hDEAD_BEEF);
        chk("mthi_busy", 64'(md_busy), 64'h0);
        md_op = 2'b11; md_a = 32'h1234;
        @(negedge clk);
        md_start = 1'b0;
        chk("mtlo_lo", 64'(lo_out), 64'h1234);
        chk("mtlo_hi", 64'(hi_out), 64'hDEAD_BEEF);
        chk("mtlo_busy", 64'(md_busy), 64'h0);

        md_start = 1'b1; md_op = 2'b00; md_a = 32'h1234_5678; md_b = 32'h9;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        md_flush = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        md_flush = 1'b0;
        chk("flush_busy", 64'(md_busy), 64'h0);
        repeat (40) @(negedge clk);
        chk("flush_hi", 64'(hi_out), 64'hDEAD_BEEF);
        chk("flush_lo", 64'(lo_out), 64'h1234);
        chk("flush_nodone", 64'(done_cnt), 64'(d0));

        md_start = 1'b1; md_op = 2'b00; md_a = 32'h77; md_b = 32'h5;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_hi", 64'(hi_out), 64'h0);
        chk("mrst_lo", 64'(lo_out), 64'h0);
        chk("mrst_busy", 64'(md_busy), 64'h0);

        md_start = 1'b1; md_flush = 1'b1; md_op = 2'b10; md_a = 32'h5;
        @(negedge clk);
        md_start = 1'b0; md_flush = 1'b0;
        chk("startflush_hi", 64'(hi_out), 64'h0);

`ifdef MULDIV_SIGNED_EN
        md_signed = 1'b1;
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, lat);
        chk("sdiv_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("sdiv_lo", 64'(lo_out), 64'hFFFF_FFFD);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd4, lat);
        chk("smul_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("smul_lo", 64'(lo_out), 64'hFFFF_FFF4);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("sovf_hi", 64'(hi_out), 64'h0);
        chk("sovf_lo", 64'(lo_out), 64'h8000_0000);
        md_signed = 1'b0;
`endif

        d0 = done_cnt;
        for (int i = 0; i < 6000; i++) begin
            r = $urandom;
            md_start = (r % 4 == 0);
            md_flush = ($urandom % 64 == 0);
            rst      = ($urandom % 3000 == 0);
            md_op    = 2'($urandom);
            md_a     = $urandom;
            case ($urandom % 8)
                0:       md_b = '0;
                1:       md_b = 32'($urandom_range(1, 15));
                default: md_b = $urandom;
            endcase
`ifdef MULDIV_SIGNED_EN
            md_signed = 1'($urandom);
`endif
            @(negedge clk);
        end
        md_start = 1'b0; md_flush = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rand_done_seen", 64'(done_cnt - d0 > 10), 64'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
